spi_bist_engine: RTL
====================

SPI_BIST_ENGINE -- requirements
Module: spi_bist_engine

Interface
REQ-001 Parameters SHALL be, one per line:
- WIDTH, 8, transfer word width, >=4.
- NUM_PATTERNS, 16, transfers per run, >=1.
- SEED, 8'hF0 (WIDTH bits), LFSR start value, nonzero.
- TAPS, 8'hB8 (WIDTH bits), LFSR feedback mask.
- TIMEOUT, 64, maximum WAIT cycles per transfer, >=2.
REQ-002 Ports SHALL be as follows. The block has one clock. Reset is synchronous and active-high.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a run.
- mode  in  1  0 = user patterns, 1 = LFSR patterns; sampled at accepted start.
- user_mosi  in  WIDTH  user MOSI pattern.
- user_miso  in  WIDTH  user MISO pattern.
- xfer_done  in  1  responder pulse: SPI transfer complete, rx data valid.
- slave_rx_data  in  WIDTH  word received by the slave (MOSI path).
- master_rx_data  in  WIDTH  word received by the master (MISO path).
- xfer_start  out  1  single-cycle pulse launching one SPI transfer.
- mosi_pattern  out  WIDTH  word for the master to send.
- miso_pattern  out  WIDTH  word for the slave to return.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next accepted start or reset.
- pass  out  1  valid while done; 1 = no errors and no timeout.
- timeout  out  1  run aborted by timeout.
- err_count  out  $clog2(NUM_PATTERNS+1)  number of failing transfers.
- first_fail_idx  out  max(1,$clog2(NUM_PATTERNS))  index of the first failing transfer.
- first_fail_mosi  out  1  MOSI mismatch on the first failing transfer.
- first_fail_miso  out  1  MISO mismatch on the first failing transfer.

Function
REQ-003 The FSM SHALL have the states IDLE, ISSUE, WAIT, CHECK, NEXT and DONE.
REQ-004 Accepting start (IDLE or DONE):
- Conditions: start=1 in IDLE or DONE.
- Actions: clear err_count, timeout, done, pass and the first_fail_* outputs; set idx=0; load the LFSR with SEED; latch mode, user_mosi and user_miso.
- Next state: ISSUE.
REQ-005 A start pulse in ISSUE, WAIT, CHECK or NEXT SHALL be ignored.
REQ-006 ISSUE SHALL assert xfer_start for exactly one cycle, then go to WAIT with the wait timer cleared to 0.
REQ-007 Patterns:
- LFSR mode: mosi_pattern=lfsr and miso_pattern=~lfsr.
- User mode: mosi_pattern and miso_pattern are the latched user words for every transfer.
- Both patterns SHALL stay stable from ISSUE through CHECK.
REQ-008 WAIT behaviour:
- xfer_done=1: capture both rx words, go to CHECK.
- Otherwise, timer==TIMEOUT-1: set timeout=1, go to DONE.
- Otherwise: increment the timer.
- xfer_done in any other state SHALL be ignored.
REQ-009 CHECK SHALL compute:
- mosi_err = (captured slave_rx_data != mosi_pattern).
- miso_err = (captured master_rx_data != miso_pattern).
REQ-010 If mosi_err or miso_err is 1:
- err_count increments by 1.
- On the first such transfer of the run only, first_fail_idx=idx, first_fail_mosi=mosi_err and first_fail_miso=miso_err are captured.
REQ-011 CHECK SHALL go to DONE if idx==NUM_PATTERNS-1, otherwise to NEXT.
REQ-012 NEXT SHALL:
- Advance the LFSR: lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}.
- Load SEED instead if that next value is 0.
- Increment idx and go to ISSUE.
- The LFSR advances in both modes; its value is only used in LFSR mode.
REQ-013 busy SHALL be 1 in ISSUE, WAIT, CHECK and NEXT, and 0 in IDLE and DONE.
REQ-014 DONE SHALL hold done=1, with pass = (err_count==0 && !timeout).
REQ-015 The first_fail_* outputs SHALL be meaningful only when err_count>0; they hold 0 otherwise.
REQ-016 Transfer timing SHALL be 4 cycles per transfer plus responder latency; there is no overlap between transfers.

Reset
REQ-017 reset=1 at any clock edge, in any state, SHALL produce on the next cycle:
- state=IDLE, lfsr=SEED, idx=0, wait timer=0.
- All outputs 0, except mosi_pattern=SEED and miso_pattern=~SEED.
REQ-018 A reset that aborts a run SHALL leave no residue; the next start behaves as from power-up.

Verification
REQ-019 LFSR mode, echo responder (xfer_done 10 cycles after xfer_start):
- mosi_pattern sequence is F0, E1, C2, ...
- miso_pattern sequence is 0F, 1E, 3D, ...
- After 16 transfers: done=1, pass=1, err_count=0.
REQ-020 Responder flips master_rx_data bit0 on transfer 3 only:
- err_count=1, first_fail_idx=3, first_fail_miso=1, first_fail_mosi=0, pass=0.
REQ-021 Responder never asserts xfer_done:
- timeout=1 and done=1 after 64 WAIT cycles of transfer 0; pass=0; busy=0.
REQ-022 User mode, user_mosi=A5, user_miso=3C, echo responder:
- All 16 transfers carry A5/3C; pass=1.
- Corrupting slave_rx_data on transfers 2 and 9 gives err_count=2, first_fail_idx=2, first_fail_mosi=1.
REQ-023 Reset asserted in WAIT of transfer 5:
- Next cycle shows the reset values of REQ-017.
- A new start replays from mosi_pattern=F0 with err_count=0.
REQ-024 Ignored inputs:
- start pulsed during WAIT: no effect.
- xfer_done pulsed in IDLE or ISSUE: no state change and no error counted.

Source files
------------

// File: rtl/spi_bist_engine_if.sv
// Host/responder bundle of the SPI BIST engine; "master" is the engine side, "slave" the host/responder side.
// Widths of the error counter and failing-index fields follow NUM_PATTERNS.
interface spi_bist_engine_if #(
   parameter int WIDTH        = 8,
   parameter int NUM_PATTERNS = 16
);
   localparam int CNT_W = $clog2(NUM_PATTERNS + 1);
   localparam int IDX_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;

   logic             start;
   logic             mode;
   logic [WIDTH-1:0] user_mosi;
   logic [WIDTH-1:0] user_miso;
   logic             xfer_done;
   logic [WIDTH-1:0] slave_rx_data;
   logic [WIDTH-1:0] master_rx_data;
   logic             xfer_start;
   logic [WIDTH-1:0] mosi_pattern;
   logic [WIDTH-1:0] miso_pattern;
   logic             busy;
   logic             done;
   logic             pass;
   logic             timeout;
   logic [CNT_W-1:0] err_count;
   logic [IDX_W-1:0] first_fail_idx;
   logic             first_fail_mosi;
   logic             first_fail_miso;

   modport master (
      input  start, mode, user_mosi, user_miso, xfer_done, slave_rx_data, master_rx_data,
      output xfer_start, mosi_pattern, miso_pattern, busy, done, pass, timeout,
             err_count, first_fail_idx, first_fail_mosi, first_fail_miso
   );

   modport slave (
      output start, mode, user_mosi, user_miso, xfer_done, slave_rx_data, master_rx_data,
      input  xfer_start, mosi_pattern, miso_pattern, busy, done, pass, timeout,
             err_count, first_fail_idx, first_fail_mosi, first_fail_miso
   );
endinterface

// File: rtl/spi_bist_engine.sv
// SPI loopback BIST: issues NUM_PATTERNS transfers (user or LFSR words) and checks both rx paths.
// 4 cycles per transfer plus responder latency, no overlap; waits on xfer_done up to TIMEOUT cycles.
module spi_bist_engine #(
   parameter int               WIDTH        = 8,
   parameter int               NUM_PATTERNS = 16,
   parameter logic [WIDTH-1:0] SEED         = 8'hF0,
   parameter logic [WIDTH-1:0] TAPS         = 8'hB8,
   parameter int               TIMEOUT      = 64
) (
   input  logic              clk,
   input  logic              reset,
   spi_bist_engine_if.master bus
);
   localparam int CNT_W = $clog2(NUM_PATTERNS + 1);
   localparam int IDX_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
   localparam int TMR_W = $clog2(TIMEOUT);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PATTERNS - 1);
   localparam logic [TMR_W-1:0] LAST_TMR = TMR_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_NEXT, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] lfsr_q, lfsr_d, lfsr_step;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             mode_q, mode_d;
   logic [WIDTH-1:0] umosi_q, umosi_d, umiso_q, umiso_d;
   logic [WIDTH-1:0] rx_s_q, rx_s_d, rx_m_q, rx_m_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic             tmo_q, tmo_d;
   logic [IDX_W-1:0] ff_idx_q, ff_idx_d;
   logic             ff_mosi_q, ff_mosi_d, ff_miso_q, ff_miso_d;
   logic [WIDTH-1:0] mosi_pat, miso_pat;
   logic             mosi_err, miso_err;

   assign lfsr_step = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
   assign mosi_pat  = mode_q ? lfsr_q : umosi_q;
   assign miso_pat  = mode_q ? ~lfsr_q : umiso_q;
   assign mosi_err  = (rx_s_q != mosi_pat);
   assign miso_err  = (rx_m_q != miso_pat);

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (bus.start) state_d = S_ISSUE;
         S_ISSUE:        state_d = S_WAIT;
         S_WAIT: begin
            if (bus.xfer_done)          state_d = S_CHECK;
            else if (timer_q == LAST_TMR) state_d = S_DONE;
         end
         S_CHECK:        state_d = (idx_q == LAST_IDX) ? S_DONE : S_NEXT;
         S_NEXT:         state_d = S_ISSUE;
         default:        state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.xfer_start = (state_q == S_ISSUE);
      bus.busy       = (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                       (state_q == S_CHECK) || (state_q == S_NEXT);
      bus.done       = (state_q == S_DONE);
      bus.pass       = (state_q == S_DONE) && (err_q == '0) && !tmo_q;
   end

   always_comb begin
      lfsr_d    = lfsr_q;    idx_d     = idx_q;     timer_d   = timer_q;
      mode_d    = mode_q;    umosi_d   = umosi_q;   umiso_d   = umiso_q;
      rx_s_d    = rx_s_q;    rx_m_d    = rx_m_q;    err_d     = err_q;
      tmo_d     = tmo_q;     ff_idx_d  = ff_idx_q;  ff_mosi_d = ff_mosi_q;
      ff_miso_d = ff_miso_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               err_d     = '0;  tmo_d     = 1'b0; ff_idx_d = '0;
               ff_mosi_d = 1'b0; ff_miso_d = 1'b0; idx_d    = '0;
               lfsr_d    = SEED; mode_d   = bus.mode;
               umosi_d   = bus.user_mosi; umiso_d = bus.user_miso;
            end
         end
         S_ISSUE: timer_d = '0;
         S_WAIT: begin
            if (bus.xfer_done) begin
               rx_s_d = bus.slave_rx_data;
               rx_m_d = bus.master_rx_data;
            end else if (timer_q == LAST_TMR) begin
               tmo_d = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_CHECK: begin
            if (mosi_err || miso_err) begin
               err_d = err_q + 1'b1;
               // Only the first failing transfer of a run is recorded.
               if (err_q == '0) begin
                  ff_idx_d  = idx_q;
                  ff_mosi_d = mosi_err;
                  ff_miso_d = miso_err;
               end
            end
         end
         S_NEXT: begin
            lfsr_d = (lfsr_step == '0) ? SEED : lfsr_step;
            idx_d  = idx_q + 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         // mode_q resets to LFSR so the idle patterns show SEED / ~SEED.
         lfsr_q    <= SEED; idx_q   <= '0;   timer_q <= '0;  mode_q <= 1'b1;
         umosi_q   <= '0;   umiso_q <= '0;   rx_s_q  <= '0;  rx_m_q <= '0;
         err_q     <= '0;   tmo_q   <= 1'b0; ff_idx_q <= '0;
         ff_mosi_q <= 1'b0; ff_miso_q <= 1'b0;
      end else begin
         lfsr_q    <= lfsr_d;  idx_q   <= idx_d;   timer_q  <= timer_d; mode_q <= mode_d;
         umosi_q   <= umosi_d; umiso_q <= umiso_d; rx_s_q   <= rx_s_d;  rx_m_q <= rx_m_d;
         err_q     <= err_d;   tmo_q   <= tmo_d;   ff_idx_q <= ff_idx_d;
         ff_mosi_q <= ff_mosi_d; ff_miso_q <= ff_miso_d;
      end
   end

   assign bus.mosi_pattern    = mosi_pat;
   assign bus.miso_pattern    = miso_pat;
   assign bus.timeout         = tmo_q;
   assign bus.err_count       = err_q;
   assign bus.first_fail_idx  = ff_idx_q;
   assign bus.first_fail_mosi = ff_mosi_q;
   assign bus.first_fail_miso = ff_miso_q;
endmodule
